// File: rtl/ls_queue_pkg.sv
// ls_queue_pkg: shared definitions for the load/store queue.
//   OPENUM_W        - opcode width
//   ls_op_e         - memory opcodes; loads occupy the low codes so is_load is one compare
//   ZERO_ROB        - ROB tag value meaning "no dependency"
//   IO_ADDR_DEFAULT - default memory-mapped IO address
package ls_queue_pkg;

    localparam int OPENUM_W = 3;

    typedef enum logic [OPENUM_W-1:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } ls_op_e;

    localparam int          ZERO_ROB        = 0;
    localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0003_0000;

    function automatic logic is_load(input logic [OPENUM_W-1:0] op);
        return op <= OP_LHU;
    endfunction

endpackage

// File: rtl/lsq_cdb_match.sv
// lsq_cdb_match: compares one operand tag against all CDB result buses.
//   q, v          - operand tag and current value
//   cdb_valid     - per-bus valid; cdb_rob_id / cdb_data hold bus k in slice k
//   hit           - some valid bus carries tag q (tag 0 never matches)
//   v_new         - value from the lowest-index matching bus, else v
module lsq_cdb_match
    import ls_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int CDB_N = 2
) (
    input  logic [ROB_W-1:0]       q,
    input  logic [XLEN-1:0]        v,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] cdb_rob_id,
    input  logic [CDB_N*XLEN-1:0]  cdb_data,
    output logic                   hit,
    output logic [XLEN-1:0]        v_new
);

    always_comb begin
        // NOTE: defaults first so every path assigns the outputs; no latch can form.
        hit   = 1'b0;
        v_new = v;
        // Walk from the highest bus down so the lowest-index match is written last and wins.
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_valid[k] && q != ROB_W'(ZERO_ROB) &&
                cdb_rob_id[k*ROB_W +: ROB_W] == q) begin
                hit   = 1'b1;
                v_new = cdb_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue between dispatcher and LS execution unit.
//   clk, rst (sync, active-high), rdy (0 = hold all state)
//   in_*            - dispatch port (valid, op, operands v/q, imm, rob_id)
//   full, occupancy - back-pressure and entry count
//   ex_*            - registered issue port; ex_busy stalls issue
//   cdb_*           - CDB_N snooped result buses
//   commit_*        - ROB commit; head_io_rob_id is the ROB head allowed to touch IO
//   io_rob_id       - tag of the head entry when it targets IO_ADDR, else 0
//   rollback        - flush all uncommitted entries
// Optional feature macro: LSQ_LOAD_BYPASS_EN lets a ready non-IO load at head+1
// issue around an uncommitted store at head when their word addresses differ.
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int              DEPTH       = 16,
    parameter int              XLEN        = 32,
    parameter int              ROB_W       = 4,
    parameter int              CDB_N       = 2,
    parameter int              FULL_MARGIN = 2,
    parameter logic [XLEN-1:0] IO_ADDR     = XLEN'(IO_ADDR_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     in_valid,
    input  logic [OPENUM_W-1:0]      in_op,
    input  logic [XLEN-1:0]          in_v1,
    input  logic [XLEN-1:0]          in_v2,
    input  logic [ROB_W-1:0]         in_q1,
    input  logic [ROB_W-1:0]         in_q2,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [ROB_W-1:0]         in_rob_id,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     ex_valid,
    output logic [OPENUM_W-1:0]      ex_op,
    output logic [XLEN-1:0]          ex_addr,
    output logic [XLEN-1:0]          ex_data,
    output logic [ROB_W-1:0]         ex_rob_id,
    input  logic                     ex_busy,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]   cdb_rob_id,
    input  logic [CDB_N*XLEN-1:0]    cdb_data,
    input  logic                     commit_valid,
    input  logic [ROB_W-1:0]         commit_rob_id,
    input  logic [ROB_W-1:0]         head_io_rob_id,
    output logic [ROB_W-1:0]         io_rob_id,
    input  logic                     rollback
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]    valid, committed;
    logic [OPENUM_W-1:0] op     [DEPTH];
    logic [XLEN-1:0]     v1     [DEPTH];
    logic [XLEN-1:0]     v2     [DEPTH];
    logic [ROB_W-1:0]    q1     [DEPTH];
    logic [ROB_W-1:0]    q2     [DEPTH];
    logic [XLEN-1:0]     imm    [DEPTH];
    logic [ROB_W-1:0]    rob_id [DEPTH];

    logic [PTR_W-1:0] head, tail, store_tail, head_step, rb_span;
    logic             store_tail_vld;

    // Insert path: capture operands broadcast in the same cycle.
    logic            ins_hit1, ins_hit2;
    logic [XLEN-1:0] ins_v1, ins_v2;

    lsq_cdb_match #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_ins_m1 (
        .q(in_q1), .v(in_v1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_data(cdb_data), .hit(ins_hit1), .v_new(ins_v1));
    lsq_cdb_match #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_ins_m2 (
        .q(in_q2), .v(in_v2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_data(cdb_data), .hit(ins_hit2), .v_new(ins_v2));

    // Per-entry snoop of the result buses.
    logic            snp_hit1 [DEPTH];
    logic            snp_hit2 [DEPTH];
    logic [XLEN-1:0] snp_v1   [DEPTH];
    logic [XLEN-1:0] snp_v2   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
        lsq_cdb_match #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_m1 (
            .q(q1[i]), .v(v1[i]), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
            .cdb_data(cdb_data), .hit(snp_hit1[i]), .v_new(snp_v1[i]));
        lsq_cdb_match #(.XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N)) u_m2 (
            .q(q2[i]), .v(v2[i]), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
            .cdb_data(cdb_data), .hit(snp_hit2[i]), .v_new(snp_v2[i]));
    end

    // Head issue decision, from registered state only (one-edge latency).
    logic [XLEN-1:0] head_addr;
    logic            head_ready, head_issue;

    assign head_addr  = v1[head] + imm[head];
    assign head_ready = valid[head] && q1[head] == ROB_W'(ZERO_ROB) && q2[head] == ROB_W'(ZERO_ROB);
    assign head_issue = !ex_busy && head_ready &&
                        (is_load(op[head]) ? (head_addr != IO_ADDR || head_io_rob_id == rob_id[head])
                                           : committed[head]);

    logic             any_issue;
    logic [PTR_W-1:0] iss_idx;
    logic [XLEN-1:0]  iss_addr;

`ifdef LSQ_LOAD_BYPASS_EN
    logic [DEPTH-1:0] consumed;
    logic [PTR_W-1:0] head_nxt1;
    logic [XLEN-1:0]  byp_addr;
    logic             byp_issue;

    assign head_nxt1 = head + PTR_W'(1);
    assign byp_addr  = v1[head_nxt1] + imm[head_nxt1];
    assign byp_issue = !ex_busy && valid[head] && !is_load(op[head]) && !committed[head] &&
                       q1[head] == ROB_W'(ZERO_ROB) &&
                       valid[head_nxt1] && !consumed[head_nxt1] && is_load(op[head_nxt1]) &&
                       q1[head_nxt1] == ROB_W'(ZERO_ROB) && q2[head_nxt1] == ROB_W'(ZERO_ROB) &&
                       byp_addr != IO_ADDR && byp_addr[XLEN-1:2] != head_addr[XLEN-1:2];
    // A bypassed load leaves a hole right behind head; head jumps over it.
    assign head_step = consumed[head_nxt1] ? head + PTR_W'(2) : head_nxt1;

    always_comb begin
        any_issue = head_issue || byp_issue;
        iss_idx   = head_issue ? head : head_nxt1;
        iss_addr  = head_issue ? head_addr : byp_addr;
    end
`else
    assign head_step = head + PTR_W'(1);

    always_comb begin
        any_issue = head_issue;
        iss_idx   = head;
        iss_addr  = head_addr;
    end
`endif

    // Entries from head through the youngest committed store survive a rollback.
    assign rb_span   = store_tail - head;
    assign full      = occupancy >= CNT_W'(DEPTH - FULL_MARGIN);
    assign io_rob_id = (valid[head] && q1[head] == ROB_W'(ZERO_ROB) && head_addr == IO_ADDR)
                       ? rob_id[head] : ROB_W'(ZERO_ROB);

    // NOTE: all sequential state uses <= so every read in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control bits are reset; payload arrays are gated by valid and need none.
            valid          <= '0;
            committed      <= '0;
            head           <= '0;
            tail           <= '0;
            occupancy      <= '0;
            store_tail     <= '0;
            store_tail_vld <= 1'b0;
            ex_valid       <= 1'b0;
            ex_op          <= '0;
            ex_addr        <= '0;
            ex_data        <= '0;
            ex_rob_id      <= '0;
`ifdef LSQ_LOAD_BYPASS_EN
            consumed       <= '0;
`endif
        end else if (rdy) begin
            if (rollback) begin
                ex_valid <= 1'b0;
                if (!store_tail_vld) begin
                    valid     <= '0;
                    committed <= '0;
                    head      <= '0;
                    tail      <= '0;
                    occupancy <= '0;
                end else begin
                    valid     <= valid & committed;
                    committed <= valid & committed;
                    tail      <= store_tail + PTR_W'(1);
                    occupancy <= CNT_W'(rb_span) + CNT_W'(1);
                end
`ifdef LSQ_LOAD_BYPASS_EN
                consumed <= '0;
`endif
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && snp_hit1[i]) begin
                        v1[i] <= snp_v1[i];
                        q1[i] <= '0;
                    end
                    if (valid[i] && snp_hit2[i]) begin
                        v2[i] <= snp_v2[i];
                        q2[i] <= '0;
                    end
                end

                ex_valid <= any_issue;
                if (any_issue) begin
                    ex_op              <= op[iss_idx];
                    ex_addr            <= iss_addr;
                    ex_data            <= v2[iss_idx];
                    ex_rob_id          <= rob_id[iss_idx];
                    valid[iss_idx]     <= 1'b0;
                    committed[iss_idx] <= 1'b0;
                end
                if (head_issue) begin
                    head <= head_step;
                    if (store_tail_vld && store_tail == head)
                        store_tail_vld <= 1'b0;
`ifdef LSQ_LOAD_BYPASS_EN
                    consumed[head_nxt1] <= 1'b0;
`endif
                end
`ifdef LSQ_LOAD_BYPASS_EN
                if (byp_issue)
                    consumed[head_nxt1] <= 1'b1;
`endif

                // Commit after issue so a fresh store commit overrides the store_tail clear.
                for (int i = 0; i < DEPTH; i++) begin
                    if (commit_valid && valid[i] && rob_id[i] == commit_rob_id) begin
                        committed[i] <= 1'b1;
                        if (!is_load(op[i])) begin
                            store_tail     <= PTR_W'(i);
                            store_tail_vld <= 1'b1;
                        end
                    end
                end

                if (in_valid) begin
                    valid[tail]     <= 1'b1;
                    committed[tail] <= 1'b0;
                    op[tail]        <= in_op;
                    v1[tail]        <= ins_v1;
                    v2[tail]        <= ins_v2;
                    q1[tail]        <= ins_hit1 ? ROB_W'(ZERO_ROB) : in_q1;
                    q2[tail]        <= ins_hit2 ? ROB_W'(ZERO_ROB) : in_q2;
                    imm[tail]       <= in_imm;
                    rob_id[tail]    <= in_rob_id;
                    tail            <= tail + PTR_W'(1);
                end

                if (in_valid && !any_issue)
                    occupancy <= occupancy + CNT_W'(1);
                else if (!in_valid && any_issue)
                    occupancy <= occupancy - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: directed self-checking bench for ls_queue (default parameters).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_ls_queue;
    import ls_queue_pkg::*;

    localparam int DEPTH = 16, XLEN = 32, ROB_W = 4, CDB_N = 2, FULL_MARGIN = 2;

    logic                   clk = 1'b0;
    logic                   rst, rdy, in_valid, ex_busy, commit_valid, rollback;
    logic [OPENUM_W-1:0]    in_op;
    logic [XLEN-1:0]        in_v1, in_v2, in_imm;
    logic [ROB_W-1:0]       in_q1, in_q2, in_rob_id, commit_rob_id, head_io_rob_id;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*ROB_W-1:0] cdb_rob_id;
    logic [CDB_N*XLEN-1:0]  cdb_data;
    logic                   full, ex_valid;
    logic [$clog2(DEPTH):0] occupancy;
    logic [OPENUM_W-1:0]    ex_op;
    logic [XLEN-1:0]        ex_addr, ex_data;
    logic [ROB_W-1:0]       ex_rob_id, io_rob_id;

    int total = 0;
    int bad   = 0;

    ls_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .CDB_N(CDB_N),
               .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_op(in_op), .in_v1(in_v1), .in_v2(in_v2),
        .in_q1(in_q1), .in_q2(in_q2), .in_imm(in_imm), .in_rob_id(in_rob_id),
        .full(full), .occupancy(occupancy),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr), .ex_data(ex_data),
        .ex_rob_id(ex_rob_id), .ex_busy(ex_busy),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .head_io_rob_id(head_io_rob_id), .io_rob_id(io_rob_id), .rollback(rollback));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [OPENUM_W-1:0] op, input logic [XLEN-1:0] v1, v2, imm,
                       input logic [ROB_W-1:0] q1, q2, rob);
        in_valid  = 1'b1;
        in_op     = op;
        in_v1     = v1;
        in_v2     = v2;
        in_imm    = imm;
        in_q1     = q1;
        in_q2     = q2;
        in_rob_id = rob;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic commit(input logic [ROB_W-1:0] rob);
        commit_valid  = 1'b1;
        commit_rob_id = rob;
        tick();
        commit_valid  = 1'b0;
    endtask

    task automatic flush();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; ex_busy = 1'b0; commit_valid = 1'b0;
        rollback = 1'b0; in_op = '0; in_v1 = '0; in_v2 = '0; in_imm = '0; in_q1 = '0;
        in_q2 = '0; in_rob_id = '0; commit_rob_id = '0; head_io_rob_id = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_occ", occupancy, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_full", full, 0);
        check("rst_ex_addr", ex_addr, 0);
        check("rst_io", io_rob_id, 0);

        // Ready load issues on the edge after insertion.
        put(OP_LW, 32'h100, 0, 4, 0, 0, 1);
        check("t1_occ_ins", occupancy, 1);
        check("t1_no_issue_yet", ex_valid, 0);
        tick();
        check("t1_ex_valid", ex_valid, 1);
        check("t1_ex_addr", ex_addr, 32'h104);
        check("t1_ex_rob", ex_rob_id, 1);
        check("t1_occ_iss", occupancy, 0);
        tick();
        check("t1_pulse", ex_valid, 0);

        // rdy=0 freezes everything, including ex_valid.
        put(OP_LW, 32'h10, 0, 0, 0, 0, 2);
        rdy = 1'b0;
        tick();
        check("stall_occ", occupancy, 1);
        check("stall_no_issue", ex_valid, 0);
        rdy = 1'b1;
        tick();
        check("stall_issue", ex_valid, 1);
        rdy = 1'b0;
        tick();
        check("stall_hold_ex", ex_valid, 1);
        rdy = 1'b1;
        tick();
        check("stall_pulse_end", ex_valid, 0);

        // Store captures v2 from bus1 at insert; waits for commit.
        cdb_valid  = 2'b11;
        cdb_rob_id = {4'd3, 4'd7};
        cdb_data   = {32'hAB, 32'h11};
        put(OP_SW, 32'h40, 0, 0, 0, 3, 4);
        cdb_valid  = '0;
        tick();
        tick();
        check("t2_wait_commit", ex_valid, 0);
        check("t2_occ", occupancy, 1);
        commit(4);
        check("t2_commit_edge", ex_valid, 0);
        tick();
        check("t2_ex_valid", ex_valid, 1);
        check("t2_ex_data", ex_data, 32'hAB);
        check("t2_ex_addr", ex_addr, 32'h40);
        check("t2_ex_op", ex_op, OP_SW);

        // Snoop: both buses hit, bus0 wins.
        put(OP_LW, 0, 0, 8, 6, 0, 6);
        tick();
        check("snp_wait", ex_valid, 0);
        cdb_valid  = 2'b11;
        cdb_rob_id = {4'd6, 4'd6};
        cdb_data   = {32'h900, 32'h500};
        tick();
        cdb_valid  = '0;
        check("snp_capture_edge", ex_valid, 0);
        tick();
        check("snp_issue", ex_valid, 1);
        check("snp_addr", ex_addr, 32'h508);

        // IO load waits for the ROB head.
        head_io_rob_id = 4'd2;
        put(OP_LW, 32'h30000, 0, 0, 0, 0, 5);
        check("t3_io_rob", io_rob_id, 5);
        tick();
        check("t3_blocked", ex_valid, 0);
        check("t3_occ", occupancy, 1);
        head_io_rob_id = 4'd5;
        tick();
        check("t3_issue", ex_valid, 1);
        check("t3_addr", ex_addr, 32'h30000);
        check("t3_io_clear", io_rob_id, 0);
        head_io_rob_id = 4'd0;

        // Fill to DEPTH-FULL_MARGIN with uncommitted stores.
        for (int i = 0; i < 13; i++)
            put(OP_SW, 32'h1000, i, 0, 0, 0, 4'(i + 1));
        check("t4_not_full", full, 0);
        check("t4_occ13", occupancy, 13);
        put(OP_SW, 32'h1000, 13, 0, 0, 0, 14);
        check("t4_full", full, 1);
        check("t4_occ14", occupancy, 14);
        commit(1);
        check("t4_occ_commit", occupancy, 14);
        put(OP_SW, 32'h1000, 14, 0, 0, 0, 15);
        check("t4_ins_iss_valid", ex_valid, 1);
        check("t4_ins_iss_rob", ex_rob_id, 1);
        check("t4_ins_iss_occ", occupancy, 14);
        flush();
        check("t4_flush_occ", occupancy, 0);
        check("t4_flush_full", full, 0);
        check("t4_flush_ex", ex_valid, 0);

        // Rollback keeps the committed store only.
        ex_busy = 1'b1;
        put(OP_SW, 32'h80, 32'h11, 0, 0, 0, 1);
        put(OP_SW, 32'h84, 32'h22, 0, 0, 0, 2);
        put(OP_LW, 32'h88, 0, 0, 0, 0, 3);
        check("t5_occ3", occupancy, 3);
        commit(1);
        check("t5_busy", ex_valid, 0);
        flush();
        check("t5_rb_occ", occupancy, 1);
        check("t5_rb_ex", ex_valid, 0);
        ex_busy = 1'b0;
        tick();
        check("t5_drain", ex_valid, 1);
        check("t5_drain_rob", ex_rob_id, 1);
        check("t5_drain_data", ex_data, 32'h11);
        check("t5_drain_occ", occupancy, 0);
        put(OP_LW, 32'h10, 0, 0, 0, 0, 4);
        check("t5_tail_ins", ex_valid, 0);
        tick();
        check("t5_tail_issue", ex_valid, 1);
        check("t5_tail_rob", ex_rob_id, 4);

        flush();
`ifdef LSQ_LOAD_BYPASS_EN
        // Load at a different word bypasses the uncommitted store.
        put(OP_SW, 32'h200, 32'h55, 0, 0, 0, 1);
        put(OP_LW, 32'h204, 0, 0, 0, 0, 2);
        check("t6_occ2", occupancy, 2);
        tick();
        check("t6_byp_valid", ex_valid, 1);
        check("t6_byp_addr", ex_addr, 32'h204);
        check("t6_byp_occ", occupancy, 1);
        commit(1);
        check("t6_commit_edge", ex_valid, 0);
        tick();
        check("t6_st_issue", ex_rob_id, 1);
        check("t6_st_occ", occupancy, 0);
        put(OP_LW, 32'h300, 0, 0, 0, 0, 3);
        tick();
        check("t6_skip_valid", ex_valid, 1);
        check("t6_skip_rob", ex_rob_id, 3);
        flush();
        // Same word: no bypass.
        put(OP_SW, 32'h200, 32'h66, 0, 0, 0, 4);
        put(OP_LW, 32'h200, 0, 0, 0, 0, 5);
        tick();
        check("t6_same_word", ex_valid, 0);
        check("t6_same_occ", occupancy, 2);
        commit(4);
        tick();
        check("t6_same_st", ex_rob_id, 4);
        tick();
        check("t6_same_ld", ex_rob_id, 5);
        check("t6_same_addr", ex_addr, 32'h200);
`else
        // In-order: the load waits behind the uncommitted store.
        put(OP_SW, 32'h200, 32'h55, 0, 0, 0, 1);
        put(OP_LW, 32'h204, 0, 0, 0, 0, 2);
        tick();
        check("t6_inorder_wait", ex_valid, 0);
        check("t6_inorder_occ", occupancy, 2);
        commit(1);
        tick();
        check("t6_inorder_st", ex_rob_id, 1);
        tick();
        check("t6_inorder_ld_valid", ex_valid, 1);
        check("t6_inorder_ld", ex_rob_id, 2);
        check("t6_inorder_addr", ex_addr, 32'h204);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
